// File: rtl/seq_slice_eq_ctrl_pkg.sv
// rtl/seq_slice_eq_ctrl_pkg.sv - shared types and defaults for the slice equality controller
package seq_slice_eq_ctrl_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SLICE = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Index width for a slice counter; never narrower than one bit
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_slice_eq_ctrl_if.sv
// rtl/seq_slice_eq_ctrl_if.sv - start/busy/done request bundle for the slice equality controller
interface seq_slice_eq_ctrl_if
  import seq_slice_eq_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
);

  localparam int NSLICES = WIDTH / SLICE;
  localparam int IDXW    = idx_width(NSLICES);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             eq;
  logic [IDXW-1:0]  mismatch_slice;

  modport master (
    output start, a, b,
    input  busy, done, eq, mismatch_slice
  );

  modport slave (
    input  start, a, b,
    output busy, done, eq, mismatch_slice
  );

endinterface

// File: rtl/seq_slice_eq_ctrl_slice_eq_cmp.sv
// rtl/seq_slice_eq_ctrl_slice_eq_cmp.sv - combinational equality of one operand slice
module slice_eq_cmp
  import seq_slice_eq_ctrl_pkg::*;
#(
  parameter int SLICE = DEF_SLICE
) (
  input  logic [SLICE-1:0] i_x,
  input  logic [SLICE-1:0] i_y,
  output logic             o_match
);

  assign o_match = (i_x == i_y);

endmodule

// File: rtl/seq_slice_eq_ctrl.sv
// rtl/seq_slice_eq_ctrl.sv - multi-cycle operand equality through one shared slice comparator
module seq_slice_eq_ctrl
  import seq_slice_eq_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic               clk,
  input  logic               rst_n,
  seq_slice_eq_ctrl_if.slave bus
);

  localparam int NSLICES = WIDTH / SLICE;
  localparam int IDXW    = idx_width(NSLICES);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICES - 1);

  generate
    if ((SLICE < 1) || (WIDTH < SLICE) || ((WIDTH % SLICE) != 0)) begin : g_bad_geometry
      $error("seq_slice_eq_ctrl: WIDTH must be a positive multiple of SLICE");
    end
  endgenerate

  state_e           r_state;
  logic [IDXW-1:0]  r_idx;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_busy;
  logic             r_done;
  logic             r_eq;
  logic [IDXW-1:0]  r_mismatch;

  logic [SLICE-1:0] w_a_slice;
  logic [SLICE-1:0] w_b_slice;
  logic             w_match;

  // Route slice r_idx of both captured operands to the shared comparator
  always_comb begin
    w_a_slice = '0;
    w_b_slice = '0;
    for (int i = 0; i < NSLICES; i++) begin
      if (r_idx == IDXW'(i)) begin
        w_a_slice = r_a[i*SLICE +: SLICE];
        w_b_slice = r_b[i*SLICE +: SLICE];
      end
    end
  end

  slice_eq_cmp #(
    .SLICE (SLICE)
  ) u_slice_eq_cmp (
    .i_x     (w_a_slice),
    .i_y     (w_b_slice),
    .o_match (w_match)
  );

  // Sequencer: accept in IDLE/DONE, walk slices LSB-first, stop on first mismatch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_eq       <= 1'b0;
      r_mismatch <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_idx   <= '0;
            r_state <= ST_CMP;
            r_busy  <= 1'b1;
          end
        end
        ST_CMP: begin
          if (!w_match) begin
            r_eq       <= 1'b0;
            r_mismatch <= r_idx;
            r_state    <= ST_DONE;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
          end else if (r_idx == LAST_IDX) begin
            r_eq       <= 1'b1;
            r_mismatch <= '0;
            r_state    <= ST_DONE;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_DONE: begin
          r_done <= 1'b0;
          // A start seen during the done cycle is taken immediately, no idle bubble
          if (bus.start) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_idx   <= '0;
            r_state <= ST_CMP;
            r_busy  <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy           = r_busy;
  assign bus.done           = r_done;
  assign bus.eq             = r_eq;
  assign bus.mismatch_slice = r_mismatch;

endmodule

// File: tb/tb_seq_slice_eq_ctrl.sv
// tb/tb_seq_slice_eq_ctrl.sv - self-checking bench for seq_slice_eq_ctrl
module tb_seq_slice_eq_ctrl;
  import seq_slice_eq_ctrl_pkg::*;

  localparam int W  = 16;
  localparam int S  = 4;
  localparam int NS = W / S;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  seq_slice_eq_ctrl_if #(.WIDTH(W), .SLICE(S)) bus ();

  seq_slice_eq_ctrl #(.WIDTH(W), .SLICE(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference: first differing slice found by plain integer arithmetic
  task automatic model(input logic [W-1:0] ta, input logic [W-1:0] tv,
                       output logic exp_eq, output int exp_mm, output int exp_lat);
    int va;
    int vb;
    int sa;
    int sb;
    va = int'(ta);
    vb = int'(tv);
    exp_eq  = 1'b1;
    exp_mm  = 0;
    exp_lat = NS;
    for (int k = 0; k < NS; k++) begin
      sa = (va / (1 << (k * S))) % (1 << S);
      sb = (vb / (1 << (k * S))) % (1 << S);
      if (exp_eq && (sa != sb)) begin
        exp_eq  = 1'b0;
        exp_mm  = k;
        exp_lat = k + 1;
      end
    end
  endtask

  // Present a request for one edge; returns 1 time unit after the accept edge
  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tv);
    bus.a     = ta;
    bus.b     = tv;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Cycles from the current sample point until done is seen, bounded
  task automatic wait_done(output int lat, output int busy_cnt, output bit to);
    lat      = 0;
    busy_cnt = 0;
    to       = 1'b0;
    while ((bus.done !== 1'b1) && !to) begin
      if (bus.busy === 1'b1) busy_cnt++;
      @(posedge clk);
      #1;
      lat++;
      if (lat > 40) to = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    checks++; if (bus.eq !== 1'b0) begin errors++; $display("FAIL reset_eq: got %b expected 0", bus.eq); end
    checks++; if (bus.mismatch_slice !== '0) begin errors++; $display("FAIL reset_mm: got %0d expected 0", bus.mismatch_slice); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    logic [W-1:0] va [4];
    logic [W-1:0] vb [4];
    logic exp_eq;
    int   exp_mm;
    int   exp_lat;
    int   lat;
    int   bc;
    bit   to;
    va[0] = 16'hA5C3; vb[0] = 16'hA5C3;
    va[1] = 16'h0001; vb[1] = 16'h0000;
    va[2] = 16'h1234; vb[2] = 16'h9234;
    va[3] = 16'h1204; vb[3] = 16'h1234;
    for (int i = 0; i < 4; i++) begin
      model(va[i], vb[i], exp_eq, exp_mm, exp_lat);
      start_op(va[i], vb[i]);
      wait_done(lat, bc, to);
      checks++; if (to) begin errors++; $display("FAIL dir%0d_timeout: got no done expected done", i); end
      checks++; if (lat != exp_lat) begin errors++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, exp_lat); end
      checks++; if (bc != exp_lat) begin errors++; $display("FAIL dir%0d_busy_cycles: got %0d expected %0d", i, bc, exp_lat); end
      checks++; if (bus.eq !== exp_eq) begin errors++; $display("FAIL dir%0d_eq: got %b expected %b", i, bus.eq, exp_eq); end
      checks++; if (int'(bus.mismatch_slice) != exp_mm) begin errors++; $display("FAIL dir%0d_mm: got %0d expected %0d", i, bus.mismatch_slice, exp_mm); end
      @(posedge clk);
      #1;
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL dir%0d_done_pulse: got %b expected 0", i, bus.done); end
      checks++; if (bus.eq !== exp_eq) begin errors++; $display("FAIL dir%0d_eq_hold: got %b expected %b", i, bus.eq, exp_eq); end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] ta;
    logic [W-1:0] tv;
    logic [W-1:0] flip;
    logic exp_eq;
    int   exp_mm;
    int   exp_lat;
    int   lat;
    int   bc;
    bit   to;
    int   k;
    for (int n = 0; n < 30; n++) begin
      ta = W'($urandom);
      tv = ta;
      case ($urandom_range(0, 3))
        0: ;
        1: tv = W'($urandom);
        default: begin
          k    = $urandom_range(0, NS - 1);
          flip = W'($urandom_range(1, (1 << S) - 1));
          tv   = tv ^ (flip << (k * S));
        end
      endcase
      model(ta, tv, exp_eq, exp_mm, exp_lat);
      start_op(ta, tv);
      bus.a = W'($urandom);
      bus.b = W'($urandom);
      wait_done(lat, bc, to);
      checks++; if (to || (lat != exp_lat)) begin errors++; $display("FAIL rnd%0d_latency: got %0d expected %0d (a=%h b=%h)", n, lat, exp_lat, ta, tv); end
      checks++; if (bus.eq !== exp_eq) begin errors++; $display("FAIL rnd%0d_eq: got %b expected %b (a=%h b=%h)", n, bus.eq, exp_eq, ta, tv); end
      checks++; if (int'(bus.mismatch_slice) != exp_mm) begin errors++; $display("FAIL rnd%0d_mm: got %0d expected %0d (a=%h b=%h)", n, bus.mismatch_slice, exp_mm, ta, tv); end
      @(posedge clk);
      #1;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic test_start_during_cmp();
    logic exp_eq;
    int   exp_mm;
    int   exp_lat;
    int   lat;
    int   bc;
    bit   to;
    int   extra;
    model(16'h1234, 16'h9234, exp_eq, exp_mm, exp_lat);
    start_op(16'h1234, 16'h9234);
    @(posedge clk);
    #1;
    bus.a     = 16'hFFFF;
    bus.b     = 16'hFFFF;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(lat, bc, to);
    lat = lat + 2;
    checks++; if (to || (lat != exp_lat)) begin errors++; $display("FAIL ign_latency: got %0d expected %0d", lat, exp_lat); end
    checks++; if (bus.eq !== exp_eq) begin errors++; $display("FAIL ign_eq: got %b expected %b", bus.eq, exp_eq); end
    checks++; if (int'(bus.mismatch_slice) != exp_mm) begin errors++; $display("FAIL ign_mm: got %0d expected %0d", bus.mismatch_slice, exp_mm); end
    extra = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if ((bus.done === 1'b1) || (bus.busy === 1'b1)) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL ign_no_second_op: got %0d active cycles expected 0", extra); end
  endtask

  task automatic test_back_to_back();
    int lat;
    int bc;
    bit to;
    bus.a     = 16'h0001;
    bus.b     = 16'h0000;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.a = 16'h0F0F;
    bus.b = 16'h0F0F;
    @(posedge clk);
    #1;
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL b2b_first_done: got %b expected 1", bus.done); end
    checks++; if (bus.eq !== 1'b0) begin errors++; $display("FAIL b2b_first_eq: got %b expected 0", bus.eq); end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    checks++; if ((bus.busy !== 1'b1) || (bus.done !== 1'b0)) begin errors++; $display("FAIL b2b_no_bubble: got busy=%b done=%b expected busy=1 done=0", bus.busy, bus.done); end
    checks++; if (bus.eq !== 1'b0) begin errors++; $display("FAIL b2b_eq_held: got %b expected 0", bus.eq); end
    wait_done(lat, bc, to);
    checks++; if (to || (lat != NS)) begin errors++; $display("FAIL b2b_second_latency: got %0d expected %0d", lat, NS); end
    checks++; if (bus.eq !== 1'b1) begin errors++; $display("FAIL b2b_second_eq: got %b expected 1", bus.eq); end
    @(posedge clk);
    #1;
    checks++; if ((bus.done !== 1'b0) || (bus.busy !== 1'b0)) begin errors++; $display("FAIL b2b_idle_after: got busy=%b done=%b expected 0 0", bus.busy, bus.done); end
  endtask

  task automatic test_async_reset();
    int lat;
    int bc;
    bit to;
    int seen;
    start_op(16'hA5C3, 16'hA5C3);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL arst_done: got %b expected 0", bus.done); end
    checks++; if (bus.eq !== 1'b0) begin errors++; $display("FAIL arst_eq: got %b expected 0", bus.eq); end
    bus.a     = 16'h3C3C;
    bus.b     = 16'h3C3C;
    bus.start = 1'b1;
    seen = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if ((bus.done === 1'b1) || (bus.busy === 1'b1)) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL arst_quiet: got %0d active cycles expected 0", seen); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL arst_first_accept: got busy=%b expected 1", bus.busy); end
    wait_done(lat, bc, to);
    checks++; if (to || (lat != NS)) begin errors++; $display("FAIL arst_fresh_latency: got %0d expected %0d", lat, NS); end
    checks++; if (bus.eq !== 1'b1) begin errors++; $display("FAIL arst_fresh_eq: got %b expected 1", bus.eq); end
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_during_cmp();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/seq_slice_eq_ctrl.md
Name: seq_slice_eq_ctrl

Overview:
Multi-cycle equality controller that compares two WIDTH-bit operands one SLICE-bit slice per cycle through a single shared slice comparator.
Sequences the slices from LSB slice upward and terminates early on the first mismatching slice.
Reports the result through a start/busy/done handshake.
Sits between operand-producing logic and the small combinational equality comparators already in the assign1 comparator family, reusing one comparator instead of instantiating a full-width one.

Parameters:
WIDTH, 16, operand width in bits; must be an integer multiple of SLICE (elaboration-time error otherwise).
SLICE, 4, bits compared per cycle; width of the shared slice comparator.
NSLICES, WIDTH/SLICE, derived (localparam); number of slices.
IDXW, max(1, clog2(NSLICES)), derived (localparam); slice index width.

Ports:
clk  input  1  single clock, all state on rising edge.
rst_n  input  1  reset, asynchronous assert, active-low.
start  input  1  request; sampled only when the controller is accepting (IDLE or DONE).
a  input  WIDTH  operand A; captured on accepted start.
b  input  WIDTH  operand B; captured on accepted start.
busy  output  1  high while in CMP.
done  output  1  one-cycle pulse, result valid.
eq  output  1  1 = operands equal; updated on entry to DONE, held until next DONE.
mismatch_slice  output  IDXW  index of first differing slice; valid when done & ~eq, held with eq.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, busy=0, done=0, eq=0, mismatch_slice=0, internal idx=0, operand registers=0.
- FSM states:
  - IDLE: start=1 -> capture a/b, idx<=0, go CMP. Otherwise stay.
  - CMP: compare slice idx of the captured operands via the slice comparator.
    - Mismatch -> eq<=0, mismatch_slice<=idx, go DONE.
    - Match and idx==NSLICES-1 -> eq<=1, mismatch_slice<=0, go DONE.
    - Match otherwise -> idx<=idx+1, stay in CMP.
  - DONE: done=1 for exactly this cycle.
    - start=1 -> capture, idx<=0, go CMP (back-to-back, no bubble).
    - Else go IDLE.
- Outputs are registered/state-decoded, with no combinational path from inputs: busy=(state==CMP), done=(state==DONE).
- Latency, counted from the start-accept edge to the done cycle:
  - Full match: done asserts NSLICES cycles after accept.
  - Mismatch at slice k: done asserts k+1 cycles after accept.
- start while in CMP is ignored and not queued. a/b changes during CMP have no effect, since operands were captured at accept.
- idx never wraps: CMP exits at NSLICES-1 at the latest.
- NSLICES==1: CMP lasts one cycle.
- Async reset mid-CMP: immediately returns to the reset values. No done pulse; the partial result is discarded.
- Reset released with start=1: the first accept occurs at the first clk edge after deassertion.
- Slice comparison is pure bitwise equality of a_r[idx*SLICE +: SLICE] vs b_r[idx*SLICE +: SLICE]. No X-propagation dependencies.

Decomposition:
- Shared package cmp_pkg:
  - State encoding typedef (IDLE/CMP/DONE, 2 bits).
  - Default WIDTH/SLICE constants.
- One natural sub-module: slice_eq_cmp.
  - Combinational, parameterised by SLICE.
  - Inputs x,y [SLICE-1:0]; output match.
  - Instantiated once and fed by a slice mux on idx.
- Slice mux and FSM stay in the top.

Test Plan:
(WIDTH=16, SLICE=4)
1. Reset, then start with a=b=16'hA5C3 -> busy 4 cycles; done one cycle, 4 cycles after accept; eq=1, mismatch_slice=0.
2. a=16'h0001, b=16'h0000 -> done 1 cycle after accept; eq=0, mismatch_slice=0; busy high exactly 1 cycle.
3. a=16'h1234, b=16'h9234 -> done 4 cycles after accept; eq=0, mismatch_slice=3. Then a=16'h1204, b=16'h1234 -> done after 2 cycles, mismatch_slice=1.
4. start pulsed again during CMP with a=b=16'hFFFF -> ignored; the original result is reported, and no second done follows without a new start.
5. start held high through the DONE cycle with new a=b=16'h0F0F -> busy the very next cycle; second done 4 cycles later with eq=1; eq is held from the first result until then.
6. Assert rst_n low asynchronously mid-CMP (2nd slice) -> busy/done/eq drop to 0 without waiting for clk; no done pulse. After release, a fresh start completes normally.
